// File: rtl/gpio_input_port_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_port_pkg
// Description : Shared constants for the GPIO input port (bus width, bit
//               offset of the fall-event field, pin limit, read selects).
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_input_port_pkg;

    localparam int   DATA_W    = 16;   // system data bus width
    localparam int   FALL_OFS  = 8;    // fall flags / fall enables start at this bit
    localparam int   MAX_WIDTH = 8;    // largest supported pin count

    localparam logic SEL_LEVEL = 1'b0; // dataSel value: read debounced levels
    localparam logic SEL_EVENT = 1'b1; // dataSel value: read rise/fall flags

endpackage : gpio_input_port_pkg
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debounce
// Description : One input pin: two-flop synchronizer, stability counter and
//               accepted level, with single-cycle rise/fall pulses that
//               coincide with the edge at which the level changes.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic pinIn,
    output logic lvl,
    output logic riseP,
    output logic fallP
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value from which one more differing sample completes the filter
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             lvl_q,   lvl_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             w_toggle;

    // Next-state: synchronize, count consecutive samples that differ from
    // the accepted level, and flip the level once the run is long enough
    always_comb begin
        sync1_d  = pinIn;
        sync2_d  = sync1_q;
        lvl_d    = lvl_q;
        cnt_d    = cnt_q;
        w_toggle = 1'b0;
        if (sync2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            w_toggle = 1'b1;
            lvl_d    = ~lvl_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset puts the pin in a quiet low state with no event
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulses are taken from the toggle decision so the parent's flags land
    // on the same edge as the level change
    always_comb begin
        lvl   = lvl_q;
        riseP = w_toggle & ~lvl_q;
        fallP = w_toggle &  lvl_q;
    end

endmodule : gpio_debounce
`default_nettype wire

// File: rtl/gpio_input_port.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_port
// Description : Memory-mapped GPIO input port. Debounced pin levels, sticky
//               rise/fall event flags with write-one-to-clear, maskable
//               level interrupt and a zero-latency read mux.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_port
    import gpio_input_port_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WIDTH-1:0]  pinIn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              dataSel,
    input  logic              evtClear,
    input  logic              irqEnLoad,
    output logic [DATA_W-1:0] dataOut,
    output logic              irq
);

    logic [WIDTH-1:0] w_lvl;
    logic [WIDTH-1:0] w_rise_p;
    logic [WIDTH-1:0] w_fall_p;

    logic [WIDTH-1:0] rise_q,    rise_d;
    logic [WIDTH-1:0] fall_q,    fall_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;

    // Bus bits above the implemented pins are ignored by design
    logic w_unused_din;
    assign w_unused_din = ^dataIn;

    // One filter per pin
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_pin
            gpio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .CLK   (CLK),
                .RST_N (RST_N),
                .pinIn (pinIn[i]),
                .lvl   (w_lvl[i]),
                .riseP (w_rise_p[i]),
                .fallP (w_fall_p[i])
            );
        end
    endgenerate

    // Flag and enable update: clear first, then OR in new events so a
    // same-cycle set always survives the clear
    always_comb begin
        rise_d    = rise_q;
        fall_d    = fall_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (evtClear) begin
            rise_d = rise_d & ~dataIn[WIDTH-1:0];
            fall_d = fall_d & ~dataIn[FALL_OFS +: WIDTH];
        end
        rise_d = rise_d | w_rise_p;
        fall_d = fall_d | w_fall_p;
        if (irqEnLoad) begin
            rise_en_d = dataIn[WIDTH-1:0];
            fall_en_d = dataIn[FALL_OFS +: WIDTH];
        end
    end

    // Event flags and interrupt enables
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rise_q    <= '0;
            fall_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else begin
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
        end
    end

    // Read mux and interrupt, both purely combinational from registered state
    always_comb begin
        dataOut = '0;
        if (dataSel == SEL_EVENT) begin
            dataOut[WIDTH-1:0]          = rise_q;
            dataOut[FALL_OFS +: WIDTH]  = fall_q;
        end else begin
            dataOut[WIDTH-1:0]          = w_lvl;
        end
        irq = (|(rise_q & rise_en_q)) | (|(fall_q & fall_en_q));
    end

endmodule : gpio_input_port
`default_nettype wire

// File: doc/gpio_input_port.md
# gpio_input_port

Input-side companion to the LED/GPIO output port: samples up to eight external input pins, synchronizes and debounces them, and latches sticky rise/fall events. It sits on the Hack CPU's memory-mapped I/O bus. The CPU reads debounced pin levels or event flags on a 16-bit data bus, clears events by write-one-to-clear, and receives a maskable level interrupt.

## Interface
Parameters:
- WIDTH, 4, number of input pins (1..8)
- DEBOUNCE_CYCLES, 16000, consecutive stable cycles required to accept a new level (1 ms at 16 MHz); minimum 1

Ports:
- CLK  input  1  16 MHz system clock
- RST_N  input  1  reset, asynchronous, active-low
- pinIn  input  WIDTH  raw asynchronous pin levels
- dataIn  input  16  system data input bus
- dataSel  input  1  read select: 0 = levels, 1 = events
- evtClear  input  1  write strobe, clear events selected by dataIn
- irqEnLoad  input  1  write strobe, load interrupt enables from dataIn
- dataOut  output  16  system data output bus
- irq  output  1  interrupt request, level, active-high

## Operation
- Synchronizer: two flops per pin. Both reset to 0.
- Debounce, per pin:
  - Stable level `lvl` resets to 0. Counter resets to 0 and is $clog2(DEBOUNCE_CYCLES+1) bits wide.
  - If the synchronized value equals `lvl`, the counter clears to 0.
  - Otherwise the counter increments. On the cycle the counter would reach DEBOUNCE_CYCLES, `lvl` toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `lvl`.
- Edge events:
  - `lvl` 0→1 sets rise[i].
  - `lvl` 1→0 sets fall[i].
  - Flags are sticky until cleared.
- Clear: on evtClear, clear rise[i] where dataIn[i]=1 and fall[i] where dataIn[8+i]=1.
  - If an event sets a flag on the same cycle it is cleared, set wins.
- Interrupt enables: on irqEnLoad, riseEn ← dataIn[WIDTH-1:0] and fallEn ← dataIn[8+WIDTH-1:8]. Both reset to 0.
- irq = |(rise & riseEn) | |(fall & fallEn).
- Read data:
  - dataSel=0: dataOut = levels zero-extended to 16 bits.
  - dataSel=1: dataOut = rise in [WIDTH-1:0], fall in [8+WIDTH-1:8]; all other bits 0.
- Reset behaviour: because reset forces `lvl` to 0, a pin held high through reset produces one rise event DEBOUNCE_CYCLES+2 cycles after reset release. This is intended; software clears it at init.
- Reset mid-debounce: the counter, `lvl`, flags and enables all return to 0 immediately, with no event generated.

## Timing
- Reset values: dataOut=0, irq=0.
- Latency: a pin level first sampled at edge k, and held, updates `lvl` at edge k+1+DEBOUNCE_CYCLES. The event flag sets at that same edge.
- irq is combinational from the flags and enables, so it is asserted in the cycle after the flag-setting edge with no extra register stage.
- dataOut is a combinational mux of registered state and is valid in the same cycle as dataSel (no read latency).
- evtClear and irqEnLoad are single-cycle strobes sampled at the rising CLK edge. A held strobe reapplies every cycle.
- A simultaneous evtClear and irqEnLoad is legal; both take effect.

## Structure
- Shared package: DATA_W=16, FALL_OFS=8, MAX_WIDTH=8, and read-select constants SEL_LEVEL=0, SEL_EVENT=1.
- Sub-module `gpio_debounce`, one instance per pin via generate:
  - Contains the synchronizer, counter and `lvl`.
  - Outputs `lvl`, `riseP` and `fallP` as single-cycle pulses.
- Top level holds the event flags, enables, read mux and irq.

## Test plan
Use DEBOUNCE_CYCLES=4 and WIDTH=4 for simulation.
- Reset:
  - Stimulus: RST_N low, pinIn=4'b0000.
  - Required: dataOut=0 and irq=0.
  - Stimulus: after release, hold pins low for 20 cycles.
  - Required: levels and events read 0.
- Clean edge:
  - Stimulus: pinIn[2] 0→1 sampled at edge k.
  - Required: level read 0x0004 from edge k+5, never earlier; event read 0x0004; irq stays 0 while riseEn=0.
- Glitch rejection:
  - Stimulus: pinIn[1] high for 3 cycles, then low.
  - Required: levels remain 0x0000 and events remain 0x0000 indefinitely.
- Interrupt and clear:
  - Stimulus: irqEnLoad with dataIn=0x0100, then fall pin0.
  - Required: event 0x0100 and irq=1.
  - Stimulus: evtClear with dataIn=0x0100.
  - Required: event 0x0000 and irq=0 next cycle.
- Set-wins collision:
  - Stimulus: evtClear with dataIn=0x0008 on the exact cycle rise[3] sets.
  - Required: rise[3] remains 1.
- Reset mid-debounce:
  - Stimulus: pin3 high for 3 cycles, assert RST_N low, release, keep pin3 high.
  - Required: rise[3] appears exactly 6 edges after release (the full filter restarts), never earlier.
